// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005_lsu: multi-cycle load/store unit with valid/ready request, memory and response ports.
// Store lanes are aligned at accept time; load extraction and extension happen when memory answers.
module ysyx_24100005_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wmask_o,
    input  logic              mem_resp_valid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e            state_q;
    logic              req_ready_q, resp_valid_q, resp_err_q, mem_req_valid_q, mem_we_q;
    logic [XLEN-1:0]   resp_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [NB-1:0]     mem_wmask_q;
    logic [2:0]        f3_q;
    logic [OW-1:0]     off_q;
    logic              we_q;
    logic [31:0]       cnt_q;

    logic [OW-1:0]     off;
    logic              legal, mis;
    logic [6:0]        sa_st, sa_ld;
    logic [XLEN-1:0]   wd, sh, lft, lds, ld;
    logic [NB-1:0]     wm;

    assign off = req_addr_i[OW-1:0];

    always_comb begin
        legal = req_funct3_i == 3'b111 ? 1'b0 :
                req_funct3_i == 3'b011 ? (XLEN == 64) :
                req_funct3_i == 3'b110 ? (!req_we_i && XLEN == 64) :
                req_funct3_i[2]        ? !req_we_i : 1'b1;
        mis   = |(off & OW'((4'd1 << req_funct3_i[1:0]) - 4'd1));
        // Shifting up then back down clears the lanes above the access size.
        sa_st = 7'(XLEN) - (7'd8 << req_funct3_i[1:0]);
        wd    = ((req_wdata_i << sa_st) >> sa_st) << {off, 3'b000};
        wm    = ~({NB{1'b1}} << (4'd1 << req_funct3_i[1:0])) << off;
        sa_ld = 7'(XLEN) - (7'd8 << f3_q[1:0]);
        sh    = mem_rdata_i >> {off_q, 3'b000};
        lft   = sh << sa_ld;
        lds   = $signed(lft) >>> sa_ld;
        ld    = f3_q[2] ? (lft >> sa_ld) : lds;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            f3_q            <= '0;
            off_q           <= '0;
            we_q            <= 1'b0;
            cnt_q           <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we_i;
                        f3_q        <= req_funct3_i;
                        off_q       <= off;
                        if (!legal || mis) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q         <= REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= req_we_i;
                            mem_addr_q      <= {req_addr_i[ADDR_W-1:OW], OW'(0)};
                            mem_wdata_q     <= req_we_i ? wd : '0;
                            mem_wmask_q     <= req_we_i ? wm : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        state_q         <= WAIT;
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid_i) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : ld;
                    end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_err_o      = resp_err_q;
    assign resp_rdata_o    = resp_rdata_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_wmask_o     = mem_wmask_q;
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// tb_ysyx_24100005_lsu: directed checks of a 32-bit LSU (TIMEOUT=8) and a 64-bit LSU sharing stimulus.
module tb_ysyx_24100005_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv32 = 1'b0, rv64 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        o32_req_ready, o32_resp_valid, o32_resp_err, o32_mrv, o32_mwe;
    logic [31:0] o32_rdata, o32_maddr, o32_mwdata;
    logic [3:0]  o32_mwmask;
    logic        o64_req_ready, o64_resp_valid, o64_resp_err, o64_mrv, o64_mwe;
    logic [63:0] o64_rdata, o64_mwdata;
    logic [31:0] o64_maddr;
    logic [7:0]  o64_mwmask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv32), .req_ready_o(o32_req_ready),
        .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]), .resp_valid_o(o32_resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(o32_rdata), .resp_err_o(o32_resp_err), .mem_req_valid_o(o32_mrv),
        .mem_req_ready_i(mem_req_ready), .mem_we_o(o32_mwe), .mem_addr_o(o32_maddr),
        .mem_wdata_o(o32_mwdata), .mem_wmask_o(o32_mwmask), .mem_resp_valid_i(mem_resp_valid),
        .mem_rdata_i(mem_rdata[31:0])
    );

    ysyx_24100005_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv64), .req_ready_o(o64_req_ready),
        .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .resp_valid_o(o64_resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(o64_rdata), .resp_err_o(o64_resp_err), .mem_req_valid_o(o64_mrv),
        .mem_req_ready_i(mem_req_ready), .mem_we_o(o64_mwe), .mem_addr_o(o64_maddr),
        .mem_wdata_o(o64_mwdata), .mem_wmask_o(o64_mwmask), .mem_resp_valid_i(mem_resp_valid),
        .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with minimum-latency memory; error requests must bypass memory.
    task automatic xact(input bit w64, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [63:0] md, input logic [7:0] emask,
                        input logic [63:0] ewd, input logic [63:0] erd, input logic eerr,
                        input string tag);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        if (w64) rv64 = 1'b1; else rv32 = 1'b1;
        tick();
        rv32 = 1'b0; rv64 = 1'b0;
        if (eerr) begin
            chk({tag, "/mreq"}, w64 ? o64_mrv : o32_mrv, 64'd0);
        end else begin
            chk({tag, "/mreq"}, w64 ? o64_mrv : o32_mrv, 64'd1);
            chk({tag, "/mwe"}, w64 ? o64_mwe : o32_mwe, {63'd0, we});
            chk({tag, "/maddr"}, w64 ? o64_maddr : o32_maddr, addr & (w64 ? ~32'h7 : ~32'h3));
            chk({tag, "/mask"}, w64 ? o64_mwmask : {4'd0, o32_mwmask}, emask);
            chk({tag, "/mwdata"}, w64 ? o64_mwdata : {32'd0, o32_mwdata}, ewd);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = md;
            tick();
            mem_resp_valid = 1'b0; mem_rdata = '0;
        end
        chk({tag, "/rvalid"}, w64 ? o64_resp_valid : o32_resp_valid, 64'd1);
        chk({tag, "/err"}, w64 ? o64_resp_err : o32_resp_err, {63'd0, eerr});
        chk({tag, "/rdata"}, w64 ? o64_rdata : {32'd0, o32_rdata}, erd);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "/done"}, w64 ? o64_resp_valid : o32_resp_valid, 64'd0);
        chk({tag, "/ready"}, w64 ? o64_req_ready : o32_req_ready, 64'd1);
    endtask

    initial begin
        int early;
        tick();
        chk("rst/ready32", o32_req_ready, 0);
        chk("rst/ready64", o64_req_ready, 0);
        chk("rst/rvalid", o32_resp_valid, 0);
        chk("rst/mreq", o32_mrv, 0);
        rst_n = 1'b1;
        #1;
        chk("rel/ready_before_edge", o32_req_ready, 0);
        tick();
        chk("rel/ready32", o32_req_ready, 1);
        chk("rel/ready64", o64_req_ready, 1);

        xact(0, 1, 3'b000, 32'h80000003, 64'hA5, 0, 8'h08, 64'hA5000000, 0, 0, "sb");
        xact(0, 1, 3'b001, 32'h80000002, 64'hFFFF1234, 0, 8'h0C, 64'h12340000, 0, 0, "sh");
        xact(0, 0, 3'b000, 32'h80000001, 0, 64'h8081F2F3, 0, 0, 64'hFFFFFFF2, 0, "lb");
        xact(0, 0, 3'b100, 32'h80000001, 0, 64'h8081F2F3, 0, 0, 64'h000000F2, 0, "lbu");
        xact(0, 0, 3'b101, 32'h80000002, 0, 64'h8081F2F3, 0, 0, 64'h00008081, 0, "lhu");
        xact(0, 0, 3'b001, 32'h80000002, 0, 64'h8081F2F3, 0, 0, 64'hFFFF8081, 0, "lh");
        xact(0, 0, 3'b010, 32'h80000000, 0, 64'h8081F2F3, 0, 0, 64'h8081F2F3, 0, "lw");
        xact(0, 0, 3'b001, 32'h80000001, 0, 0, 0, 0, 0, 1, "lh_mis");
        xact(0, 1, 3'b010, 32'h80000002, 0, 0, 0, 0, 0, 1, "sw_mis");
        xact(0, 0, 3'b011, 32'h80000000, 0, 0, 0, 0, 0, 1, "ld32_ill");
        xact(0, 0, 3'b110, 32'h80000000, 0, 0, 0, 0, 0, 1, "lwu32_ill");
        xact(0, 1, 3'b100, 32'h80000000, 0, 0, 0, 0, 0, 1, "sbu_ill");
        xact(0, 0, 3'b111, 32'h80000000, 0, 0, 0, 0, 0, 1, "f3_7_ill");

        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000004; rv32 = 1'b1;
        tick();
        rv32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp/mreq", o32_mrv, 1);
            chk("bp/maddr", o32_maddr, 32'h80000004);
            chk("bp/mask", o32_mwmask, 0);
            tick();
        end
        chk("bp/mreq_held", o32_mrv, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            chk("bp/rvalid", o32_resp_valid, 1);
            chk("bp/rdata", o32_rdata, 32'hDEADBEEF);
            chk("bp/err", o32_resp_err, 0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp/done", o32_resp_valid, 0);
        tick();
        chk("bp/single", o32_resp_valid, 0);

        req_funct3 = 3'b010; req_addr = 32'h80000010; rv32 = 1'b1;
        tick();
        rv32 = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        early = 0;
        repeat (7) begin
            tick();
            early += int'(o32_resp_valid);
        end
        chk("to/early", early, 0);
        tick();
        chk("to/rvalid", o32_resp_valid, 1);
        chk("to/err", o32_resp_err, 1);
        chk("to/rdata", o32_rdata, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("to/late_ignored", o32_resp_valid, 0);
        chk("to/ready", o32_req_ready, 1);
        chk("to/mreq", o32_mrv, 0);

        req_addr = 32'h80000008; rv32 = 1'b1;
        tick();
        rv32 = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst/ready", o32_req_ready, 0);
        chk("arst/rvalid", o32_resp_valid, 0);
        chk("arst/mreq", o32_mrv, 0);
        chk("arst/maddr", o32_maddr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst/ready_after", o32_req_ready, 1);
        xact(0, 0, 3'b010, 32'h80000008, 0, 64'hCAFEF00D, 0, 0, 64'hCAFEF00D, 0, "arst/lw");

        xact(1, 1, 3'b011, 32'h80000008, 64'h1122334455667788, 0, 8'hFF, 64'h1122334455667788, 0, 0, "sd64");
        xact(1, 1, 3'b010, 32'h80000004, 64'hAAAAAAAADEADBEEF, 0, 8'hF0, 64'hDEADBEEF00000000, 0, 0, "sw64");
        xact(1, 0, 3'b010, 32'h80000004, 0, 64'h8000000000000000, 0, 0, 64'hFFFFFFFF80000000, 0, "lw64");
        xact(1, 0, 3'b110, 32'h80000004, 0, 64'h8000000000000000, 0, 0, 64'h0000000080000000, 0, "lwu64");
        xact(1, 0, 3'b000, 32'h80000007, 0, 64'h7F00000000000000, 0, 0, 64'h000000000000007F, 0, "lb64");
        xact(1, 0, 3'b011, 32'h80000004, 0, 0, 0, 0, 0, 1, "ld64_mis");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_24100005_lsu.md
Name: ysyx_24100005_lsu

Overview:
- Parametrised multi-cycle load/store unit for the NPC core. Replaces the combinational DPI memory access in the top level.
- Takes one load/store request per transaction from the execute stage and drives a valid/ready memory port.
- Generates the byte-lane mask and write-data alignment for stores; performs lane extraction plus sign/zero extension for loads.
- Reports misalignment, illegal-size and timeout errors.

Parameters:
- XLEN, 32, data width in bits; legal values 32 and 64.
- ADDR_W, 32, address width in bits.
- TIMEOUT, 255, maximum cycles spent in WAIT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assertion, active-low (rst=0 resets).
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  LSU accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 field giving size and signedness.
- req_addr  in  ADDR_W  byte address (rs1 + imm).
- req_wdata  in  XLEN  store data (rs2), right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and on error.
- resp_err  out  1  misaligned, illegal funct3, or timeout.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  XLEN/8-aligned address (low bits cleared).
- mem_wdata  out  XLEN  store data shifted to its byte lanes.
- mem_wmask  out  XLEN/8  byte-lane write mask; all zeros for loads.
- mem_resp_valid  in  1  memory completes the read or write.
- mem_rdata  in  XLEN  full aligned word from memory.

Behaviour:
- Reset: while rst=0, state is IDLE and every output is 0, including req_ready. On the first edge after rst=1, req_ready is 1.
- Reset mid-transaction aborts the transaction. No response is issued.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata.
  - Illegal or misaligned request goes to RESP with resp_err=1, rdata=0, and no memory request. Otherwise go to REQ.
- REQ:
  - mem_req_valid=1, with mem_* driven from registers and held stable until handshake.
  - On mem_req_ready, go to WAIT and clear the timeout counter.
- WAIT:
  - On mem_resp_valid, latch the result and go to RESP with err=0.
  - When the counter reaches TIMEOUT (TIMEOUT>0), go to RESP with err=1 and rdata=0.
  - mem_resp_valid is ignored in every state other than WAIT.
- RESP:
  - resp_valid=1, with resp_rdata and resp_err held stable.
  - On resp_ready, go to IDLE. No back-to-back accept in the same cycle.
- Minimum latency: request accepted at edge 0; mem_req_valid in cycle 1. With mem_req_ready=1 in cycle 1 and mem_resp_valid=1 in cycle 2, resp_valid is asserted in cycle 3.
- Sizes by funct3:
  - 000 B (signed), 001 H (signed), 010 W (signed when XLEN=64), 100 BU, 101 HU.
  - 110 WU: loads only, XLEN=64 only.
  - 011 D: XLEN=64 only.
  - Stores accept only B, H, W, D.
  - Every other combination is illegal.
- Alignment: address low bits must be zero for the access size (H: bit 0; W: bits 1:0; D: bits 2:0). Byte accesses are always aligned.
- Lane arithmetic: off = addr[log2(XLEN/8)-1:0].
  - mem_wmask = ((1<<bytes)-1) << off.
  - mem_wdata = req_wdata << (8*off); unused lanes are don't-care but driven 0.
  - Load: tmp = mem_rdata >> (8*off); truncate to size, then sign- or zero-extend to XLEN.
- Store response: resp_rdata = 0, resp_err = 0 on success.

Test Plan:
- XLEN=32 store: SB addr 0x80000003, wdata 0x000000A5 → mem_addr 0x80000000, wmask 0b1000, wdata 0xA5000000, mem_we=1. Response err=0, rdata=0.
- Loads of mem_rdata 0x8081F2F3:
  - LB addr 0x80000001 → resp_rdata 0xFFFFFFF2.
  - LBU at the same address → 0x000000F2.
  - LHU addr 0x80000002 → 0x00008081.
- LH addr 0x80000001 → resp_err=1, no mem_req_valid pulse, resp_valid 1 cycle after accept.
- Backpressure: mem_req_ready low for 4 cycles and resp_ready low for 3 cycles → mem_* and resp_* outputs stable throughout; exactly one transaction completes.
- Timeout: TIMEOUT=8, mem_resp_valid never asserted → resp_err=1 exactly 8 cycles after entering WAIT. A late mem_resp_valid arriving in IDLE is ignored.
- rst=0 asserted while in WAIT → all outputs 0 immediately (asynchronous). After release, req_ready=1 and a fresh LW returns correct data.
- XLEN=64: SD 0x80000008 → wmask 0xFF. LW with mem_rdata 0x80000000_00000000 at off 4 → 0xFFFFFFFF80000000.
